btn_cmd_ctrl: RTL and testbench

Front-end controller that turns N raw push-buttons into a stream of arbitrated button commands for the stopwatch/control logic. Internally it:
- generates the slow sample tick;
- filters each synchronized button;
- runs a per-button press/hold/auto-repeat state machine;
- arbitrates pending events onto one valid/ready command port.

It replaces ad-hoc per-button debounce plus edge-detect logic at the top level.

---
 rtl/btn_cmd_pkg.sv | 11 +
 rtl/btn_chan.sv | 108 ++++++++++
 rtl/btn_cmd_ctrl.sv | 117 +++++++++++
 tb/tb_btn_cmd_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_cmd_pkg.sv
// Shared types and helpers for the button command front-end.
package btn_cmd_pkg;

   typedef enum logic [1:0] {IDLE, HELD, REPEAT} chan_state_t;

   // cmd_id width: at least one bit even for a single button
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: tick-sampled level filter plus press/hold/auto-repeat FSM.
module btn_chan
   import btn_cmd_pkg::*;
#(
   parameter int STABLE_CNT     = 16,
   parameter int HOLD_SAMPLES   = 200,
   parameter int REPEAT_SAMPLES = 40
) (
   input  logic clk,
   input  logic rst,
   input  logic tick_i,
   input  logic sample_i,
   output logic level_o,
   output logic event_o,
   output logic event_rep_o
);

   localparam int AW   = $clog2(STABLE_CNT) + 1;
   localparam int HMAX = (HOLD_SAMPLES > REPEAT_SAMPLES) ? HOLD_SAMPLES : REPEAT_SAMPLES;
   localparam int HW   = $clog2(HMAX) + 1;

   logic [AW-1:0] agree_q, agree_d;
   logic          level_q, level_d;
   chan_state_t   state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;

   always_comb begin
      agree_d = agree_q;
      level_d = level_q;
      if (tick_i) begin
         if (sample_i != level_q) begin
            if (agree_q == AW'(STABLE_CNT - 1)) begin
               level_d = ~level_q;
               agree_d = '0;
            end else begin
               agree_d = agree_q + 1'b1;
            end
         end else begin
            agree_d = '0;
         end
      end
   end

   // FSM reacts to the registered level; release beats the hold counter
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      event_o     = 1'b0;
      event_rep_o = 1'b0;
      if (tick_i) begin
         unique case (state_q)
            IDLE: begin
               if (level_q) begin
                  state_d = HELD;
                  hold_d  = '0;
                  event_o = 1'b1;
               end
            end
            HELD: begin
               if (!level_q) begin
                  state_d = IDLE;
                  hold_d  = '0;
               end else if (hold_q == HW'(HOLD_SAMPLES - 1)) begin
                  state_d     = REPEAT;
                  hold_d      = '0;
                  event_o     = 1'b1;
                  event_rep_o = 1'b1;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            REPEAT: begin
               if (!level_q) begin
                  state_d = IDLE;
                  hold_d  = '0;
               end else if (hold_q == HW'(REPEAT_SAMPLES - 1)) begin
                  hold_d      = '0;
                  event_o     = 1'b1;
                  event_rep_o = 1'b1;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               hold_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         agree_q <= '0;
         level_q <= 1'b0;
         state_q <= IDLE;
         hold_q  <= '0;
      end else begin
         agree_q <= agree_d;
         level_q <= level_d;
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/btn_cmd_ctrl.sv
// Button front-end: synchronizers, sample tick, per-channel filters/FSMs,
// one-deep pending slot per button and a fixed-priority command register.
module btn_cmd_ctrl
   import btn_cmd_pkg::*;
#(
   parameter int N_BTN          = 4,
   parameter int SAMPLE_DIV     = 500000,
   parameter int STABLE_CNT     = 16,
   parameter int HOLD_SAMPLES   = 200,
   parameter int REPEAT_SAMPLES = 40
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [N_BTN-1:0]               btn_raw,
   output logic [N_BTN-1:0]               btn_level,
   output logic                           cmd_valid,
   input  logic                           cmd_ready,
   output logic [id_width(N_BTN)-1:0]     cmd_id,
   output logic                           cmd_repeat
);

   localparam int IDW = id_width(N_BTN);
   localparam int DW  = $clog2(SAMPLE_DIV) + 1;

   logic [N_BTN-1:0] sync1_q, sync2_q;
   logic [N_BTN-1:0] pend_q, pend_d, prep_q, prep_d;
   logic [N_BTN-1:0] ev, ev_rep;
   logic [DW-1:0]    div_q, div_d;
   logic             tick;
   logic             vld_q, vld_d, rep_q, rep_d;
   logic [IDW-1:0]   id_q, id_d;
   logic             load, grant_vld;
   logic [IDW-1:0]   grant_id;

   assign tick  = (div_q == DW'(SAMPLE_DIV - 1));
   assign div_d = tick ? '0 : div_q + 1'b1;

   for (genvar g = 0; g < N_BTN; g++) begin : g_chan
      btn_chan #(
         .STABLE_CNT    (STABLE_CNT),
         .HOLD_SAMPLES  (HOLD_SAMPLES),
         .REPEAT_SAMPLES(REPEAT_SAMPLES)
      ) u_chan (
         .clk        (clk),
         .rst        (rst),
         .tick_i     (tick),
         .sample_i   (sync2_q[g]),
         .level_o    (btn_level[g]),
         .event_o    (ev[g]),
         .event_rep_o(ev_rep[g])
      );
   end

   always_comb begin
      grant_vld = 1'b0;
      grant_id  = '0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            grant_vld = 1'b1;
            grant_id  = IDW'(i);
         end
      end
   end

   assign load = ~vld_q | cmd_ready;

   // A new event overrides a same-cycle grant; otherwise it merges so a
   // pending press is never downgraded to a repeat.
   always_comb begin
      pend_d = pend_q;
      prep_d = prep_q;
      vld_d  = vld_q;
      id_d   = id_q;
      rep_d  = rep_q;
      if (load) begin
         vld_d = grant_vld;
         if (grant_vld) begin
            id_d             = grant_id;
            rep_d            = prep_q[grant_id];
            pend_d[grant_id] = 1'b0;
         end
      end
      for (int i = 0; i < N_BTN; i++) begin
         if (ev[i]) begin
            prep_d[i] = pend_d[i] ? (prep_q[i] & ev_rep[i]) : ev_rep[i];
            pend_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         div_q   <= '0;
         pend_q  <= '0;
         prep_q  <= '0;
         vld_q   <= 1'b0;
         id_q    <= '0;
         rep_q   <= 1'b0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         div_q   <= div_d;
         pend_q  <= pend_d;
         prep_q  <= prep_d;
         vld_q   <= vld_d;
         id_q    <= id_d;
         rep_q   <= rep_d;
      end
   end

   assign cmd_valid  = vld_q;
   assign cmd_id     = id_q;
   assign cmd_repeat = rep_q;

endmodule

// File: tb/tb_btn_cmd_ctrl.sv
// Directed bench for btn_cmd_ctrl with a tick-level behavioural model
// checked every cycle, plus literal expectations per scenario.
module tb_btn_cmd_ctrl;
   localparam int NB = 4, SD = 4, SC = 3, HS = 5, RS = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] btn_raw = '0;
   logic [3:0] btn_level;
   logic       cmd_valid, cmd_ready = 1'b1, cmd_repeat;
   logic [1:0] cmd_id;

   btn_cmd_ctrl #(.N_BTN(NB), .SAMPLE_DIV(SD), .STABLE_CNT(SC),
                  .HOLD_SAMPLES(HS), .REPEAT_SAMPLES(RS)) dut (
      .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
      .cmd_repeat(cmd_repeat));

   always #5 clk = ~clk;

   int errors = 0, checks = 0, cyc_no = 0;
   int log_id[$], log_rep[$], log_cyc[$];

   // model: held/age per button instead of an explicit state machine
   int  m_cnt, agree[NB], age[NB];
   bit  [NB-1:0] s1, s2, m_lvl, held, pend, prep;
   bit  m_v, m_rep;
   int  m_id;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_no);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; s1 = '0; s2 = '0; m_lvl = '0; held = '0; pend = '0; prep = '0;
      m_v = 0; m_rep = 0; m_id = 0;
      for (int i = 0; i < NB; i++) begin agree[i] = 0; age[i] = 0; end
   endtask

   task automatic model_step();
      bit [NB-1:0] ev, evr;
      int grant;
      bit tk;
      if (rst) begin model_reset(); return; end
      tk = (m_cnt % SD) == SD - 1;
      ev = '0; evr = '0; grant = -1;
      if (tk) begin
         for (int i = 0; i < NB; i++) begin
            if (held[i]) begin
               if (!m_lvl[i]) held[i] = 0;
               else begin
                  age[i]++;
                  if (age[i] >= HS && (age[i] - HS) % RS == 0) begin ev[i] = 1; evr[i] = 1; end
               end
            end else if (m_lvl[i]) begin
               held[i] = 1; age[i] = 0; ev[i] = 1;
            end
            if (s2[i] != m_lvl[i]) begin
               agree[i]++;
               if (agree[i] == SC) begin m_lvl[i] = ~m_lvl[i]; agree[i] = 0; end
            end else agree[i] = 0;
         end
      end
      if (!m_v || cmd_ready) begin
         m_v = 0;
         for (int i = 0; i < NB; i++) if (pend[i] && grant < 0) grant = i;
         if (grant >= 0) begin m_v = 1; m_id = grant; m_rep = prep[grant]; end
      end
      for (int i = 0; i < NB; i++) begin
         if (ev[i]) begin
            prep[i] = (pend[i] && i != grant) ? (prep[i] & evr[i]) : evr[i];
            pend[i] = 1;
         end else if (i == grant) pend[i] = 0;
      end
      s2 = s1; s1 = btn_raw;
      m_cnt++;
   endtask

   task automatic compare();
      chk("btn_level", int'(btn_level), int'(m_lvl));
      chk("cmd_valid", int'(cmd_valid), int'(m_v));
      if (m_v) begin
         chk("cmd_id", int'(cmd_id), m_id);
         chk("cmd_repeat", int'(cmd_repeat), int'(m_rep));
      end
      chk("tick", int'(dut.tick), int'(!rst && (m_cnt % SD) == SD - 1));
   endtask

   task automatic cyc();
      if (cmd_valid && cmd_ready && !rst) begin
         log_id.push_back(int'(cmd_id));
         log_rep.push_back(int'(cmd_repeat));
         log_cyc.push_back(cyc_no);
      end
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
      cyc_no++;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cyc();
   endtask

   task automatic wait_log(input int n, input int bound, input string name);
      int k = 0;
      while (log_id.size() < n && k < bound) begin cyc(); k++; end
      chk(name, int'(log_id.size() >= n), 1);
   endtask

   initial begin
      int base, t0, nt, last, gap_bad, n0, n1p;
      model_reset();
      run(3);
      chk("rst_level", int'(btn_level), 0);
      chk("rst_valid", int'(cmd_valid), 0);
      chk("rst_id", int'(cmd_id), 0);
      chk("rst_repeat", int'(cmd_repeat), 0);
      rst = 1'b0;

      // divider: 25 ticks, 4 clk apart, in the first 100 cycles
      nt = 0; last = -1; gap_bad = 0;
      for (int k = 0; k < 100; k++) begin
         cyc();
         if (dut.tick) begin
            if (last >= 0 && cyc_no - last != 4) gap_bad++;
            last = cyc_no; nt++;
         end
      end
      chk("tick_count", nt, 25);
      chk("tick_gap", gap_bad, 0);

      // clean press on button 2, raw held 48 clk
      base = log_id.size();
      btn_raw[2] = 1'b1; t0 = cyc_no;
      while (!btn_level[2] && cyc_no - t0 < 30) cyc();
      chk("press_lat_min", int'(cyc_no - t0 >= (SC - 1) * SD + 2), 1);
      chk("press_lat_max", int'(cyc_no - t0 <= SC * SD + 2), 1);
      while (cyc_no - t0 < 48) cyc();
      btn_raw[2] = 1'b0;
      run(40);
      chk("clean_count", log_id.size() - base, 5);
      chk("clean_id0", log_id[base], 2);
      chk("clean_rep0", log_rep[base], 0);
      chk("clean_id1", log_id[base+1], 2);
      chk("clean_rep1", log_rep[base+1], 1);
      chk("clean_rep_gap", log_cyc[base+2] - log_cyc[base+1], RS * SD);
      chk("clean_rep4", log_rep[base+4], 1);
      chk("clean_release", int'(btn_level[2]), 0);

      // bounce on button 0: toggle every 4 clk for 20 ticks
      base = log_id.size();
      for (int k = 0; k < 20; k++) begin
         btn_raw[0] = ~k[0];
         run(4);
      end
      btn_raw[0] = 1'b0;
      run(20);
      chk("bounce_cmds", log_id.size() - base, 0);
      chk("bounce_level", int'(btn_level[0]), 0);

      // simultaneous presses on buttons 3 and 1
      base = log_id.size();
      btn_raw[3] = 1'b1; btn_raw[1] = 1'b1;
      wait_log(base + 2, 40, "simul_timeout");
      btn_raw[3] = 1'b0; btn_raw[1] = 1'b0;
      run(40);
      chk("simul_count", log_id.size() - base, 2);
      chk("simul_id0", log_id[base], 1);
      chk("simul_rep0", log_rep[base], 0);
      chk("simul_id1", log_id[base+1], 3);
      chk("simul_rep1", log_rep[base+1], 0);
      chk("simul_consec", log_cyc[base+1] - log_cyc[base], 1);

      // backpressure: short press on 0, long press on 1 merging repeats
      base = log_id.size();
      cmd_ready = 1'b0;
      btn_raw[0] = 1'b1; t0 = cyc_no;
      run(8);
      btn_raw[1] = 1'b1;
      run(8);
      btn_raw[0] = 1'b0;
      run(32);
      chk("bp_hold_valid", int'(cmd_valid), 1);
      chk("bp_hold_id", int'(cmd_id), 0);
      chk("bp_hold_rep", int'(cmd_repeat), 0);
      cmd_ready = 1'b1;
      run(24);
      btn_raw[1] = 1'b0;
      run(40);
      chk("bp_id0", log_id[base], 0);
      chk("bp_rep0", log_rep[base], 0);
      chk("bp_id1", log_id[base+1], 1);
      chk("bp_rep1", log_rep[base+1], 0);
      chk("bp_consec", log_cyc[base+1] - log_cyc[base], 1);
      chk("bp_id2", log_id[base+2], 1);
      chk("bp_rep2", log_rep[base+2], 1);
      n0 = 0; n1p = 0;
      for (int k = base; k < log_id.size(); k++) begin
         if (log_id[k] == 0) n0++;
         if (log_id[k] == 1 && log_rep[k] == 0) n1p++;
      end
      chk("bp_btn0_once", n0, 1);
      chk("bp_btn1_press_once", n1p, 1);

      // reset while button 2 is auto-repeating and a command is stalled
      cmd_ready = 1'b0;
      btn_raw[2] = 1'b1;
      run(60);
      chk("mid_valid_before", int'(cmd_valid), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", int'(cmd_valid), 0);
      chk("mid_rst_level", int'(btn_level), 0);
      chk("mid_rst_id", int'(cmd_id), 0);
      chk("mid_rst_rep", int'(cmd_repeat), 0);
      model_reset();
      run(2);
      rst = 1'b0; cmd_ready = 1'b1;
      base = log_id.size();
      wait_log(base + 1, 40, "mid_repress_timeout");
      chk("mid_repress_id", log_id[base], 2);
      chk("mid_repress_rep", log_rep[base], 0);
      btn_raw[2] = 1'b0;
      run(30);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end
endmodule
